vga_stream_checker: RTL and testbench

//  Synthesizable, parametrised frame checker for the VGA pixel stream.
//  - Compares one frame of per-channel pixel data inside a configurable view window against expected pixels supplied over a valid/ready port.
//  - Reports per-channel mismatch counts and the first failing coordinate, so on-board runs get frame self-checking without the simulator.
//  - Sits beside VGA_controller, tapping its pixel strobe, position and colour outputs.

---
 rtl/vga_stream_checker.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_vga_stream_checker.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_checker.sv
// -----------------------------------------------------------------------------
// vga_stream_checker
//
// Purpose:
//   Frame checker that sits beside the VGA controller and taps its pixel
//   strobe, position and colour outputs. During one frame (between a rising
//   and the next falling edge of Vsync_i) every pixel that lands inside the
//   view window is compared channel by channel against an expected pixel
//   taken from a small valid/ready FIFO. Per-channel mismatch counts, the
//   number of in-window pixels, an underflow flag and the first failing
//   coordinate are reported, so on-board runs can self-check whole frames.
//
// Optional feature (compile-time macro VGA_CHK_CRC_EN):
//   When defined, adds output Crc_o, a CRC-16-CCITT (poly 0x1021,
//   init 0xFFFF) over Pix_data_i of every in-window pixel, channel 0 first,
//   bits of each channel MSB first. Without the macro there is no Crc_o port
//   and no CRC logic.
//
// Ports:
//   Clock          in   system clock
//   Resetn         in   asynchronous active-low reset
//   Start_i        in   arm/restart pulse (clears results and FIFO)
//   Vsync_i        in   vertical sync; rise starts checking, fall ends it
//   Pix_en_i       in   pixel strobe, one cycle per displayed pixel
//   Pix_x_i/_y_i   in   coordinate of the strobed pixel
//   Pix_data_i     in   observed pixel, channel 0 in the LSBs
//   Exp_valid_i    in   expected pixel valid
//   Exp_data_i     in   expected pixel, same packing as Pix_data_i
//   Exp_ready_o    out  FIFO accepts an expected pixel
//   Busy_o         out  armed or checking
//   Done_o         out  frame finished, results frozen
//   Underflow_o    out  sticky: in-window pixel met an empty FIFO
//   Mismatch_cnt_o out  per-channel saturating mismatch counts
//   Pixel_cnt_o    out  saturating in-window pixel count
//   First_err_*    out  valid flag and coordinate of the first mismatch
//   Crc_o          out  (VGA_CHK_CRC_EN only) running CRC of in-window pixels
// -----------------------------------------------------------------------------
module vga_stream_checker #(
    parameter int NUM_CH      = 3,
    parameter int CH_W        = 8,
    parameter int POS_W       = 10,
    parameter int VIEW_LEFT   = 160,
    parameter int VIEW_RIGHT  = 480,
    parameter int VIEW_TOP    = 120,
    parameter int VIEW_BOTTOM = 360,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 20
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     Start_i,
    input  logic                     Vsync_i,
    input  logic                     Pix_en_i,
    input  logic [POS_W-1:0]         Pix_x_i,
    input  logic [POS_W-1:0]         Pix_y_i,
    input  logic [NUM_CH*CH_W-1:0]   Pix_data_i,
    input  logic                     Exp_valid_i,
    input  logic [NUM_CH*CH_W-1:0]   Exp_data_i,
    output logic                     Exp_ready_o,
    output logic                     Busy_o,
    output logic                     Done_o,
    output logic                     Underflow_o,
    output logic [NUM_CH*CNT_W-1:0]  Mismatch_cnt_o,
    output logic [CNT_W-1:0]         Pixel_cnt_o,
    output logic                     First_err_v_o,
    output logic [POS_W-1:0]         First_err_x_o,
    output logic [POS_W-1:0]         First_err_y_o
`ifdef VGA_CHK_CRC_EN
    ,output logic [15:0]             Crc_o
`endif
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int                DATA_W   = NUM_CH * CH_W;
    localparam int                AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]       DEPTH_P  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]       CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]       CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
    localparam logic [POS_W-1:0]  LEFT_P   = POS_W'(VIEW_LEFT);
    localparam logic [POS_W-1:0]  RIGHT_P  = POS_W'(VIEW_RIGHT);
    localparam logic [POS_W-1:0]  TOP_P    = POS_W'(VIEW_TOP);
    localparam logic [POS_W-1:0]  BOTTOM_P = POS_W'(VIEW_BOTTOM);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_CHECKING = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_W'(1));
    endfunction

`ifdef VGA_CHK_CRC_EN
    // One CRC-16-CCITT update over a whole pixel: channel 0 first, each
    // channel MSB first, one shift per bit.
    function automatic logic [15:0] crc_step(input logic [15:0]       crc_in,
                                             input logic [DATA_W-1:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int b = CH_W - 1; b >= 0; b--) begin
                fb = c[15] ^ data[ch*CH_W + b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // State and storage
    // -------------------------------------------------------------------------
    state_t               state_r;
    state_t               state_nxt_s;
    logic                 vsync_d_r;

    logic [DATA_W-1:0]    fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [AW:0]          count_r;
    logic [AW:0]          count_nxt_s;

    logic                 rise_s;
    logic                 fall_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 accept_s;
    logic                 push_s;
    logic                 in_win_s;
    logic                 pop_s;
    logic                 under_s;
    logic [DATA_W-1:0]    head_s;
    logic [NUM_CH-1:0]    ch_diff_s;

    logic                 exp_ready_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 underflow_r;
    logic [CNT_W-1:0]     mis_cnt_r [NUM_CH];
    logic [CNT_W-1:0]     pix_cnt_r;
    logic                 fe_v_r;
    logic [POS_W-1:0]     fe_x_r;
    logic [POS_W-1:0]     fe_y_r;

    // Event decode: sync edges, FIFO handshake, window hit and per-channel compare.
    always_comb begin
        rise_s    = !vsync_d_r && Vsync_i;
        fall_s    = vsync_d_r && !Vsync_i;
        full_s    = (count_r == DEPTH_P);
        empty_s   = (count_r == CNT_ZERO);
        accept_s  = ((state_r == ST_ARMED) || (state_r == ST_CHECKING)) && !full_s;
        // Start_i wipes the FIFO and results, so nothing else may act that cycle.
        push_s    = Exp_valid_i && accept_s && !Start_i;
        in_win_s  = (state_r == ST_CHECKING) && Pix_en_i && !Start_i &&
                    (Pix_x_i >= LEFT_P) && (Pix_x_i < RIGHT_P) &&
                    (Pix_y_i >= TOP_P)  && (Pix_y_i < BOTTOM_P);
        // No bypass: a pixel that finds the FIFO empty is an underflow even
        // when an expected pixel is being pushed in the same cycle.
        pop_s     = in_win_s && !empty_s;
        under_s   = in_win_s && empty_s;
        head_s    = fifo_mem_r[rd_ptr_r];
        ch_diff_s = {NUM_CH{1'b0}};
        for (int ch = 0; ch < NUM_CH; ch++) begin
            ch_diff_s[ch] = pop_s &&
                (head_s[ch*CH_W +: CH_W] != Pix_data_i[ch*CH_W +: CH_W]);
        end
    end

    // Next FIFO occupancy and next control state.
    always_comb begin
        count_nxt_s = count_r;
        state_nxt_s = state_r;
        if (Start_i) begin
            count_nxt_s = CNT_ZERO;
            state_nxt_s = ST_ARMED;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
            case (state_r)
                ST_IDLE:     state_nxt_s = ST_IDLE;
                ST_ARMED:    state_nxt_s = rise_s ? ST_CHECKING : ST_ARMED;
                ST_CHECKING: state_nxt_s = fall_s ? ST_DONE : ST_CHECKING;
                ST_DONE:     state_nxt_s = ST_DONE;
                default:     state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Control FSM, FIFO pointers and registered status outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r     <= ST_IDLE;
            vsync_d_r   <= 1'b1;
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= CNT_ZERO;
            exp_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            vsync_d_r   <= Vsync_i;
            state_r     <= state_nxt_s;
            count_r     <= count_nxt_s;
            // Status flags are computed from the next state so they line up
            // with state_r after the edge.
            exp_ready_r <= ((state_nxt_s == ST_ARMED) || (state_nxt_s == ST_CHECKING)) &&
                           (count_nxt_s != DEPTH_P);
            busy_r      <= (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_CHECKING);
            done_r      <= (state_nxt_s == ST_DONE);
            if (Start_i) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
            end
        end
    end

    // Expected-pixel storage; contents are only read behind a valid count.
    always_ff @(posedge Clock) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= Exp_data_i;
        end
    end

    // Result counters, underflow flag and first-error capture.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            underflow_r <= 1'b0;
            pix_cnt_r   <= {CNT_W{1'b0}};
            fe_v_r      <= 1'b0;
            fe_x_r      <= {POS_W{1'b0}};
            fe_y_r      <= {POS_W{1'b0}};
            for (int ch = 0; ch < NUM_CH; ch++) begin
                mis_cnt_r[ch] <= {CNT_W{1'b0}};
            end
        end else if (Start_i) begin
            underflow_r <= 1'b0;
            pix_cnt_r   <= {CNT_W{1'b0}};
            fe_v_r      <= 1'b0;
            fe_x_r      <= {POS_W{1'b0}};
            fe_y_r      <= {POS_W{1'b0}};
            for (int ch = 0; ch < NUM_CH; ch++) begin
                mis_cnt_r[ch] <= {CNT_W{1'b0}};
            end
        end else begin
            if (under_s) begin
                underflow_r <= 1'b1;
            end
            if (in_win_s) begin
                pix_cnt_r <= sat_inc(pix_cnt_r);
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (ch_diff_s[ch]) begin
                    mis_cnt_r[ch] <= sat_inc(mis_cnt_r[ch]);
                end
            end
            // Only the first mismatching pixel of the frame is recorded.
            if ((|ch_diff_s) && !fe_v_r) begin
                fe_v_r <= 1'b1;
                fe_x_r <= Pix_x_i;
                fe_y_r <= Pix_y_i;
            end
        end
    end

`ifdef VGA_CHK_CRC_EN
    logic [15:0] crc_r;

    // Running CRC of in-window pixel data; frozen outside CHECKING.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            crc_r <= 16'hFFFF;
        end else if (Start_i) begin
            crc_r <= 16'hFFFF;
        end else if (in_win_s) begin
            crc_r <= crc_step(crc_r, Pix_data_i);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign Crc_o = crc_r;
`endif

    // -------------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // -------------------------------------------------------------------------
    assign Exp_ready_o   = exp_ready_r;
    assign Busy_o        = busy_r;
    assign Done_o        = done_r;
    assign Underflow_o   = underflow_r;
    assign Pixel_cnt_o   = pix_cnt_r;
    assign First_err_v_o = fe_v_r;
    assign First_err_x_o = fe_x_r;
    assign First_err_y_o = fe_y_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_mis_pack
        assign Mismatch_cnt_o[g*CNT_W +: CNT_W] = mis_cnt_r[g];
    end

endmodule

// File: tb/tb_vga_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_vga_stream_checker
//
// Bench for vga_stream_checker. A main instance uses a 4x2 view window
// (columns 2..5, rows 1..2) with 8-bit counters; a second instance with
// 3-bit counters is exercised for saturation. A queue-based reference model
// of the frame-checking rules tracks the main instance every cycle.
// -----------------------------------------------------------------------------
module tb_vga_stream_checker;

    localparam int L = 2, R = 6, T = 1, B = 3;
    localparam int DEPTH = 4;
    localparam int MAXC  = 255;

    logic        clk;
    logic        rst_n;

    // main instance stimulus / observation
    logic        start, vsync, pix_en, exp_valid;
    logic [9:0]  pix_x, pix_y;
    logic [23:0] pix_data, exp_data;
    logic        exp_ready, busy, done, under, fe_v;
    logic [23:0] mis_cnt;
    logic [7:0]  pix_cnt;
    logic [9:0]  fe_x, fe_y;

    // saturation instance stimulus / observation
    logic        s_start, s_vsync, s_pix_en, s_exp_valid;
    logic [9:0]  s_pix_x, s_pix_y;
    logic [23:0] s_pix_data, s_exp_data;
    logic        s_exp_ready, s_busy, s_done, s_under, s_fe_v;
    logic [8:0]  s_mis_cnt;
    logic [2:0]  s_pix_cnt;
    logic [9:0]  s_fe_x, s_fe_y;

    vga_stream_checker #(
        .NUM_CH(3), .CH_W(8), .POS_W(10),
        .VIEW_LEFT(L), .VIEW_RIGHT(R), .VIEW_TOP(T), .VIEW_BOTTOM(B),
        .FIFO_DEPTH(DEPTH), .CNT_W(8)
    ) dut (
        .Clock(clk), .Resetn(rst_n), .Start_i(start), .Vsync_i(vsync),
        .Pix_en_i(pix_en), .Pix_x_i(pix_x), .Pix_y_i(pix_y), .Pix_data_i(pix_data),
        .Exp_valid_i(exp_valid), .Exp_data_i(exp_data), .Exp_ready_o(exp_ready),
        .Busy_o(busy), .Done_o(done), .Underflow_o(under),
        .Mismatch_cnt_o(mis_cnt), .Pixel_cnt_o(pix_cnt),
        .First_err_v_o(fe_v), .First_err_x_o(fe_x), .First_err_y_o(fe_y)
    );

    vga_stream_checker #(
        .NUM_CH(3), .CH_W(8), .POS_W(10),
        .VIEW_LEFT(0), .VIEW_RIGHT(16), .VIEW_TOP(0), .VIEW_BOTTOM(1),
        .FIFO_DEPTH(DEPTH), .CNT_W(3)
    ) dut_sat (
        .Clock(clk), .Resetn(rst_n), .Start_i(s_start), .Vsync_i(s_vsync),
        .Pix_en_i(s_pix_en), .Pix_x_i(s_pix_x), .Pix_y_i(s_pix_y), .Pix_data_i(s_pix_data),
        .Exp_valid_i(s_exp_valid), .Exp_data_i(s_exp_data), .Exp_ready_o(s_exp_ready),
        .Busy_o(s_busy), .Done_o(s_done), .Underflow_o(s_under),
        .Mismatch_cnt_o(s_mis_cnt), .Pixel_cnt_o(s_pix_cnt),
        .First_err_v_o(s_fe_v), .First_err_x_o(s_fe_x), .First_err_y_o(s_fe_y)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (phase + queue) ----------------
    int          m_st;          // 0 idle, 1 armed, 2 checking, 3 done
    bit          m_vd;
    logic [23:0] m_q[$];
    int          m_mis[3];
    int          m_pix;
    bit          m_under, m_fev;
    int          m_fex, m_fey;

    task automatic model_clear();
        m_q.delete();
        for (int c = 0; c < 3; c++) m_mis[c] = 0;
        m_pix = 0; m_under = 0; m_fev = 0; m_fex = 0; m_fey = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_st = 0; m_vd = 1'b1;
    endtask

    function automatic bit m_ready();
        return ((m_st == 1) || (m_st == 2)) && (m_q.size() < DEPTH);
    endfunction

    task automatic model_update();
        bit          rdy, rise, fall, inwin, anyerr;
        logic [23:0] head;
        rdy  = m_ready();
        rise = !m_vd && vsync;
        fall = m_vd && !vsync;
        if (start) begin
            model_clear();
            m_st = 1;
        end else begin
            inwin = (m_st == 2) && pix_en && (pix_x >= L) && (pix_x < R) &&
                    (pix_y >= T) && (pix_y < B);
            if (inwin) begin
                if (m_pix < MAXC) m_pix++;
                if (m_q.size() == 0) m_under = 1'b1;
                else begin
                    head = m_q.pop_front();
                    anyerr = 1'b0;
                    for (int c = 0; c < 3; c++) begin
                        if (head[c*8 +: 8] != pix_data[c*8 +: 8]) begin
                            if (m_mis[c] < MAXC) m_mis[c]++;
                            anyerr = 1'b1;
                        end
                    end
                    if (anyerr && !m_fev) begin
                        m_fev = 1'b1; m_fex = int'(pix_x); m_fey = int'(pix_y);
                    end
                end
            end
            if (exp_valid && rdy) m_q.push_back(exp_data);
            if (m_st == 1 && rise) m_st = 2;
            else if (m_st == 2 && fall) m_st = 3;
        end
        m_vd = vsync;
    endtask

    task automatic check_model();
        chk("mdl_ready", exp_ready, m_ready());
        chk("mdl_busy", busy, (m_st == 1) || (m_st == 2));
        chk("mdl_done", done, m_st == 3);
        chk("mdl_under", under, m_under);
        for (int c = 0; c < 3; c++) chk("mdl_mis", mis_cnt[c*8 +: 8], 32'(m_mis[c]));
        chk("mdl_pix", pix_cnt, 32'(m_pix));
        chk("mdl_fev", fe_v, m_fev);
        chk("mdl_fex", fe_x, 32'(m_fex));
        chk("mdl_fey", fe_y, 32'(m_fey));
    endtask

    // One clock: model consumes current inputs, DUT samples them, compare.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_model();
    endtask

    function automatic logic [23:0] gen(input int x, input int y);
        logic [7:0] r, g, b;
        r = 8'(x * 7 + y);
        g = 8'(y * 13 + 1);
        b = 8'(x + y * 3 + 5);
        return {b, g, r};
    endfunction

    // Start, optionally supply matching expected pixels, then raster a 8x4
    // frame between a Vsync rise and fall. err_mode 1 corrupts ch0 at (3,1)
    // and ch2 at (5,2).
    task automatic run_frame(input bit with_exp, input int err_mode);
        logic [23:0] pend[$];
        logic [23:0] err;
        bit          acc;
        if (with_exp)
            for (int y = T; y < B; y++) for (int x = L; x < R; x++) pend.push_back(gen(x, y));
        start = 1'b1; step(); start = 1'b0;
        vsync = 1'b0;
        repeat (DEPTH) begin
            exp_valid = with_exp; exp_data = with_exp ? pend[0] : 24'h0;
            acc = exp_valid && m_ready();
            step();
            if (acc) void'(pend.pop_front());
        end
        exp_valid = 1'b0;
        step();
        vsync = 1'b1; step();
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                err = 24'h0;
                if (err_mode == 1 && x == 3 && y == 1) err = 24'h000001;
                if (err_mode == 1 && x == 5 && y == 2) err = 24'h010000;
                pix_en = 1'b1; pix_x = 10'(x); pix_y = 10'(y); pix_data = gen(x, y) ^ err;
                exp_valid = (pend.size() > 0);
                exp_data  = (pend.size() > 0) ? pend[0] : 24'h0;
                acc = exp_valid && m_ready();
                step();
                if (acc) void'(pend.pop_front());
                if (err_mode == 1 && x == 3 && y == 1) begin
                    chk("err1_fev", fe_v, 1);
                    chk("err1_fex", fe_x, 3);
                    chk("err1_fey", fe_y, 1);
                    chk("err1_ch0", mis_cnt[7:0], 1);
                    chk("err1_ch1", mis_cnt[15:8], 0);
                    chk("err1_ch2", mis_cnt[23:16], 0);
                end
            end
        end
        pix_en = 1'b0; exp_valid = 1'b0;
        vsync = 1'b0; step();
        step();
    endtask

    typedef struct {
        bit en;
        int x;
        int y;
        int inc;
    } win_vec_t;

    win_vec_t tbl[10];
    int       exp_pix;

    initial begin
        tbl[0] = '{1'b1, 1, 1, 0};  tbl[1] = '{1'b1, 2, 1, 1};
        tbl[2] = '{1'b1, 5, 1, 1};  tbl[3] = '{1'b1, 6, 1, 0};
        tbl[4] = '{1'b1, 2, 0, 0};  tbl[5] = '{1'b1, 5, 2, 1};
        tbl[6] = '{1'b1, 2, 3, 0};  tbl[7] = '{1'b1, 9, 9, 0};
        tbl[8] = '{1'b0, 3, 2, 0};  tbl[9] = '{1'b1, 3, 2, 1};

        rst_n = 1'b0; start = 1'b0; vsync = 1'b0; pix_en = 1'b0; exp_valid = 1'b0;
        pix_x = 10'd0; pix_y = 10'd0; pix_data = 24'h0; exp_data = 24'h0;
        s_start = 1'b0; s_vsync = 1'b0; s_pix_en = 1'b0; s_exp_valid = 1'b0;
        s_pix_x = 10'd0; s_pix_y = 10'd0; s_pix_data = 24'h0; s_exp_data = 24'h0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset state
        chk("rst_ready", exp_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_under", under, 0);
        chk("rst_mis", mis_cnt, 0);
        chk("rst_pix", pix_cnt, 0);
        chk("rst_fev", fe_v, 0);
        step();

        // arm, fill FIFO, overfill attempt, one pop re-opens ready
        start = 1'b1; step(); start = 1'b0;
        chk("arm_busy", busy, 1);
        chk("arm_ready", exp_ready, 1);
        for (int i = 0; i < DEPTH; i++) begin
            exp_valid = 1'b1; exp_data = gen(2 + i, 1); step();
        end
        chk("full_ready", exp_ready, 0);
        exp_data = 24'hABCDEF; step();
        chk("full_ready2", exp_ready, 0);
        exp_valid = 1'b0; vsync = 1'b0; step();
        vsync = 1'b1; step();
        chk("full_ready3", exp_ready, 0);
        pix_en = 1'b1; pix_x = 10'd2; pix_y = 10'd1; pix_data = gen(2, 1); step();
        pix_en = 1'b0;
        chk("pop_ready", exp_ready, 1);
        chk("pop_mis", mis_cnt, 0);

        // window boundaries with an empty FIFO (table driven)
        start = 1'b1; step(); start = 1'b0;
        vsync = 1'b0; step();
        vsync = 1'b1; step();
        exp_pix = 0;
        for (int i = 0; i < 10; i++) begin
            pix_en = tbl[i].en; pix_x = 10'(tbl[i].x); pix_y = 10'(tbl[i].y);
            pix_data = 24'($urandom);
            step();
            exp_pix += tbl[i].inc;
            chk("win_pix", pix_cnt, 32'(exp_pix));
        end
        pix_en = 1'b0;
        chk("win_under", under, 1);
        chk("win_mis", mis_cnt, 0);

        // clean frame
        run_frame(1'b1, 0);
        chk("clean_done", done, 1);
        chk("clean_mis", mis_cnt, 0);
        chk("clean_pix", pix_cnt, 8);
        chk("clean_fev", fe_v, 0);
        chk("clean_under", under, 0);

        // frame with two errors
        run_frame(1'b1, 1);
        chk("err_done", done, 1);
        chk("err_ch0", mis_cnt[7:0], 1);
        chk("err_ch1", mis_cnt[15:8], 0);
        chk("err_ch2", mis_cnt[23:16], 1);
        chk("err_fex", fe_x, 3);
        chk("err_fey", fe_y, 1);

        // no expected data at all
        run_frame(1'b0, 0);
        chk("uf_under", under, 1);
        chk("uf_pix", pix_cnt, 8);
        chk("uf_mis", mis_cnt, 0);

        // restart in the middle of checking, then a clean frame
        start = 1'b1; step(); start = 1'b0;
        vsync = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_valid = 1'b1; exp_data = 24'h5A5A5A; step();
        end
        exp_valid = 1'b0;
        vsync = 1'b1; step();
        for (int i = 0; i < 2; i++) begin
            pix_en = 1'b1; pix_x = 10'(L + i); pix_y = 10'(T); pix_data = 24'h0; step();
        end
        pix_en = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("rs_busy", busy, 1);
        chk("rs_done", done, 0);
        chk("rs_pix", pix_cnt, 0);
        chk("rs_mis", mis_cnt, 0);
        chk("rs_fev", fe_v, 0);
        chk("rs_ready", exp_ready, 1);
        run_frame(1'b1, 0);
        chk("rs2_done", done, 1);
        chk("rs2_mis", mis_cnt, 0);
        chk("rs2_pix", pix_cnt, 8);
        chk("rs2_under", under, 0);

        // asynchronous reset in the middle of a frame
        start = 1'b1; step(); start = 1'b0;
        vsync = 1'b0; step();
        vsync = 1'b1; step();
        pix_en = 1'b1; pix_x = 10'd3; pix_y = 10'd1; step();
        pix_en = 1'b0;
        #3 rst_n = 1'b0;
        #2;
        chk("arst_busy", busy, 0);
        chk("arst_pix", pix_cnt, 0);
        chk("arst_ready", exp_ready, 0);
        chk("arst_under", under, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // randomized traffic against the reference model
        for (int n = 0; n < 2500; n++) begin
            start     = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 29) == 0) vsync = ~vsync;
            pix_en    = $urandom_range(0, 1);
            pix_x     = 10'($urandom_range(0, 8));
            pix_y     = 10'($urandom_range(0, 4));
            exp_valid = $urandom_range(0, 1);
            for (int c = 0; c < 3; c++) begin
                pix_data[c*8 +: 8] = 8'($urandom_range(0, 1));
                exp_data[c*8 +: 8] = 8'($urandom_range(0, 1));
            end
            step();
        end
        start = 1'b0; pix_en = 1'b0; exp_valid = 1'b0;

        // saturation with 3-bit counters: 10 pixels, each wrong in ch0
        s_start = 1'b1; step(); s_start = 1'b0;
        s_vsync = 1'b1; step();
        for (int i = 0; i < 10; i++) begin
            s_exp_valid = 1'b1; s_exp_data = 24'h0; step();
            s_exp_valid = 1'b0;
            s_pix_en = 1'b1; s_pix_x = 10'(i); s_pix_y = 10'd0; s_pix_data = 24'h000001; step();
            s_pix_en = 1'b0;
        end
        s_vsync = 1'b0; step();
        chk("sat_ch0", s_mis_cnt[2:0], 7);
        chk("sat_ch1", s_mis_cnt[5:3], 0);
        chk("sat_ch2", s_mis_cnt[8:6], 0);
        chk("sat_pix", s_pix_cnt, 7);
        chk("sat_done", s_done, 1);
        chk("sat_under", s_under, 0);
        chk("sat_fex", s_fe_x, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
